// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: round-robin arbiter over NUM_WARPS warp slots that
// offers one warp per cycle to the dispatch stage over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              1 allows new selections; 0 freezes selection (never withdraws an offer)
//   warp_ready_mask     per-warp "instruction buffered, operands ready"
//   warp_stall_mask     per-warp "blocked (barrier/exit)"
//   m_tvalid, m_tready  issue offer handshake
//   issue_warp_id       warp id of the current offer
//   pop_valid           one-cycle pulse after each accepted issue
//   pop_warp_id         warp id to pop from the instruction buffer
//   issue_count         running count of accepted issues (wraps)
//   err                 sticky: an offered warp lost its ready bit
module warp_issue_scheduler #(
    parameter int unsigned NUM_WARPS = 32,
    parameter int unsigned WID_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_WARPS-1:0] warp_ready_mask,
    input  logic [NUM_WARPS-1:0] warp_stall_mask,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [WID_W-1:0]     issue_warp_id,
    output logic                 pop_valid,
    output logic [WID_W-1:0]     pop_warp_id,
    output logic [15:0]          issue_count,
    output logic                 err
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = WID_W + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WID_W-1:0]     issue_id_q, issue_id_d;
    logic                 pop_valid_q, pop_valid_d;
    logic [WID_W-1:0]     pop_id_q, pop_id_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 err_q, err_d;

    logic                 hs_c;
    logic [NUM_WARPS-1:0] excl_c;
    logic [WID_W-1:0]     ptr_c;
    logic [NUM_WARPS-1:0] elig_c;
    logic                 sel_found_c;
    logic [WID_W-1:0]     sel_id_c;
    logic                 load_sel_c;

    // Lowest-index set bit of vec at or above ptr, wrapping at NUM_WARPS.
    // Returns {found, id}.
    function automatic logic [WID_W:0] rr_pick(input logic [NUM_WARPS-1:0] vec,
                                               input logic [WID_W-1:0]     ptr);
        logic             found;
        logic [WID_W-1:0] id;
        logic [WID_W:0]   idx;
        found = 1'b0;
        id    = '0;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            idx = {1'b0, ptr} + IDX_W'(i);
            if (idx >= IDX_W'(NUM_WARPS)) begin
                idx = idx - IDX_W'(NUM_WARPS);
            end
            if (!found && vec[idx[WID_W-1:0]]) begin
                found = 1'b1;
                id    = idx[WID_W-1:0];
            end
        end
        return {found, id};
    endfunction

    // Selection: on an accepting edge the just-accepted warp is excluded and the
    // pointer has already advanced past it, so the re-selection sees both.
    always_comb begin
        hs_c   = (state_q == ST_OFFER) && m_tready;
        excl_c = '0;
        ptr_c  = rr_ptr_q;
        if (hs_c) begin
            excl_c = NUM_WARPS'(1) << issue_id_q;
            ptr_c  = (issue_id_q == WID_W'(NUM_WARPS - 1)) ? '0 : issue_id_q + WID_W'(1);
        end
        elig_c                  = warp_ready_mask & ~warp_stall_mask & ~excl_c;
        {sel_found_c, sel_id_c} = rr_pick(elig_c, ptr_c);
        // A new winner is latched from IDLE, or right after a handshake.
        load_sel_c = enable && sel_found_c && ((state_q == ST_IDLE) || hs_c);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an offer is held until accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_sel_c) begin
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (hs_c) begin
                    state_d = load_sel_c ? ST_OFFER : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        issue_id_d  = issue_id_q;
        pop_valid_d = hs_c;
        pop_id_d    = pop_id_q;
        count_d     = count_q;
        rr_ptr_d    = ptr_c;
        err_d       = err_q;
        if (load_sel_c) begin
            issue_id_d = sel_id_c;
        end
        if (hs_c) begin
            pop_id_d = issue_id_q;
            count_d  = count_q + CNT_W'(1);
        end
        // Offered warp lost its ready bit: flag it but keep the offer.
        if ((state_q == ST_OFFER) && !warp_ready_mask[issue_id_q]) begin
            err_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_id_q  <= '0;
            pop_valid_q <= 1'b0;
            pop_id_q    <= '0;
            count_q     <= '0;
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            issue_id_q  <= issue_id_d;
            pop_valid_q <= pop_valid_d;
            pop_id_q    <= pop_id_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            err_q       <= err_d;
        end
    end

    assign m_tvalid      = (state_q == ST_OFFER);
    assign issue_warp_id = issue_id_q;
    assign pop_valid     = pop_valid_q;
    assign pop_warp_id   = pop_id_q;
    assign issue_count   = count_q;
    assign err           = err_q;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Scoreboard bench for warp_issue_scheduler: directed phases push expected
// issue ids; a negedge monitor pops them on every handshake and checks the
// pop pulse that must follow.
module tb_warp_issue_scheduler;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] warp_ready_mask;
    logic [31:0] warp_stall_mask;
    logic        m_tvalid;
    logic        m_tready;
    logic [4:0]  issue_warp_id;
    logic        pop_valid;
    logic [4:0]  pop_warp_id;
    logic [15:0] issue_count;
    logic        err;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    logic exp_pop_v  = 1'b0;
    int   exp_pop_id = 0;

    warp_issue_scheduler #(.NUM_WARPS(32), .WID_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .warp_ready_mask (warp_ready_mask),
        .warp_stall_mask (warp_stall_mask),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .issue_warp_id   (issue_warp_id),
        .pop_valid       (pop_valid),
        .pop_warp_id     (pop_warp_id),
        .issue_count     (issue_count),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: check the pop pulse owed by the previous handshake, then score
    // any handshake presented this cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pop_v = 1'b0;
        end else begin
            chk("pop_valid", 32'(pop_valid), 32'(exp_pop_v));
            if (exp_pop_v && exp_pop_id >= 0) begin
                chk("pop_warp_id", 32'(pop_warp_id), 32'(exp_pop_id));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got id %0d want none (t=%0t)", issue_warp_id, $time);
                    exp_pop_id = -1;
                end else begin
                    exp_pop_id = exp_q.pop_front();
                    chk("issue_warp_id", 32'(issue_warp_id), 32'(exp_pop_id));
                end
                exp_pop_v = 1'b1;
            end else begin
                exp_pop_v = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Wait until every expected issue has been scored; returns at the edge of the last handshake.
    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        enable          = 1'b0;
        warp_ready_mask = '0;
        warp_stall_mask = '0;
        m_tready        = 1'b0;
        #2;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_id", 32'(issue_warp_id), 32'd0);
        chk("rst_pop", 32'(pop_valid), 32'd0);
        chk("rst_count", 32'(issue_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Round-robin sweep 0..31 then wrap to 0.
        warp_ready_mask = 32'hFFFF_FFFF;
        enable          = 1'b1;
        m_tready        = 1'b1;
        for (int i = 0; i < 32; i++) exp_q.push_back(i);
        exp_q.push_back(0);
        release_reset();
        drain("sweep");
        #1 m_tready = 1'b0;
        chk("sweep_count", 32'(issue_count), 32'd33);

        // Backpressure: warp 4 held for 5 cycles, then warp 5.
        do_reset();
        warp_ready_mask = 32'h0000_0030;
        exp_q.push_back(4);
        exp_q.push_back(5);
        release_reset();
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_tvalid", 32'(m_tvalid), 32'd1);
            chk("bp_id", 32'(issue_warp_id), 32'd4);
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
        drain("bp");
        #1 m_tready = 1'b0;
        chk("bp_count", 32'(issue_count), 32'd2);

        // Exclusion: lone warp 0 issues every other cycle.
        do_reset();
        warp_ready_mask = 32'h0000_0001;
        m_tready        = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(0);
        release_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("excl_tvalid", 32'(m_tvalid), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1 m_tready = 1'b0;
        warp_ready_mask = '0;
        chk("excl_count", 32'(issue_count), 32'd4);

        // Stall, wrap and error: prime rr_ptr to 31 with warp 30.
        do_reset();
        warp_ready_mask = 32'h4000_0000;
        m_tready        = 1'b1;
        exp_q.push_back(30);
        exp_q.push_back(31);
        exp_q.push_back(1);
        release_reset();
        @(posedge clk);
        @(posedge clk);
        #1 warp_ready_mask = 32'h8000_0003;
        warp_stall_mask = 32'h0000_0001;
        @(posedge clk);
        @(posedge clk);
        #1 m_tready = 1'b0;
        @(negedge clk);
        chk("wrap_tvalid", 32'(m_tvalid), 32'd1);
        chk("wrap_id", 32'(issue_warp_id), 32'd1);
        chk("wrap_err0", 32'(err), 32'd0);
        @(posedge clk);
        #1 warp_ready_mask = 32'h8000_0001;
        @(posedge clk);
        @(negedge clk);
        chk("err_set", 32'(err), 32'd1);
        chk("err_tvalid", 32'(m_tvalid), 32'd1);
        chk("err_id", 32'(issue_warp_id), 32'd1);
        @(posedge clk);
        #1 m_tready = 1'b1;
        warp_ready_mask = '0;
        drain("wrap");
        #1 m_tready = 1'b0;
        warp_stall_mask = '0;
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        chk("wrap_idle", 32'(m_tvalid), 32'd0);
        chk("wrap_count", 32'(issue_count), 32'd3);

        // Reset mid-offer.
        do_reset();
        warp_ready_mask = 32'h0000_0006;
        m_tready        = 1'b1;
        exp_q.push_back(1);
        release_reset();
        drain("mid");
        #1 m_tready = 1'b0;
        @(negedge clk);
        chk("mid_count1", 32'(issue_count), 32'd1);
        chk("mid_tvalid1", 32'(m_tvalid), 32'd1);
        chk("mid_id2", 32'(issue_warp_id), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_pop", 32'(pop_valid), 32'd0);
        chk("mid_rst_count", 32'(issue_count), 32'd0);
        chk("mid_rst_id", 32'(issue_warp_id), 32'd0);
        warp_ready_mask = 32'h0000_0007;
        m_tready        = 1'b1;
        exp_q.push_back(0);
        release_reset();
        @(negedge clk);
        chk("restart_tvalid", 32'(m_tvalid), 32'd1);
        chk("restart_id", 32'(issue_warp_id), 32'd0);
        drain("restart");
        #1 m_tready = 1'b0;

        // Enable gating.
        do_reset();
        warp_ready_mask = 32'hFFFF_FFFF;
        enable          = 1'b0;
        m_tready        = 1'b1;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en0_tvalid", 32'(m_tvalid), 32'd0);
        end
        @(posedge clk);
        #1 enable = 1'b1;
        exp_q.push_back(0);
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        chk("en_offer", 32'(m_tvalid), 32'd1);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("en_idle", 32'(m_tvalid), 32'd0);
        end
        chk("en_count", 32'(issue_count), 32'd1);
        m_tready = 1'b0;

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
